// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : Load/store request and response channels between the
//               pipeline memory stage (master) and a data-memory
//               responder (slave). Both channels use valid/ready.
// Signals     : req_valid, req_ready, req_we, req_addr[31:0],
//               req_wdata[31:0], req_be[3:0]           request channel
//               rsp_valid, rsp_ready, rsp_rdata[31:0],
//               rsp_err                                response channel
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Target side of the memory-stage load/store channel. Accepts
//               one request at a time, performs a byte-enabled store or a
//               word load on an internal word array and returns one
//               response. Misaligned or out-of-range accesses return an
//               error with zero data and leave the array untouched.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - dmem_if.slave (request + response channels)
// Parameters  : DEPTH_WORDS - words in the array (power of two, >= 4)
//               BASE_ADDR   - byte address of word 0 (word aligned)
//               WAIT_CYCLES - extra latency per access (0..15)
// Macro       : DMEM_WAIT_STATES_EN - when defined, a WAIT state and 4-bit
//               counter add WAIT_CYCLES of latency to every access; when
//               undefined, IDLE goes straight to RESP.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int unsigned c_AW   = $clog2(DEPTH_WORDS);
  // Span in bytes, one bit wider than an address so it cannot overflow.
  localparam logic [32:0] c_SPAN = 33'(DEPTH_WORDS) << 2;

  // Elaboration-time sanity check of the configuration.
  if ((WAIT_CYCLES > 15) || (DEPTH_WORDS < 4) ||
      ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) ||
      (BASE_ADDR[1:0] != 2'b00)) begin : g_param_check
    $error("dmem_responder: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        w_req_ready;
  logic        w_accept;
  logic        w_fire;       // this edge enters RESP and performs the access
  logic        w_acc_we;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_be;
  logic [31:0] w_off;
  logic        w_acc_err;
  logic [c_AW-1:0] w_idx;

  // Ready is masked by rst so nothing can be accepted while reset is held.
  assign w_req_ready   = (state_q == S_IDLE) && !rst;
  assign w_accept      = bus.req_valid && w_req_ready;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

`ifdef DMEM_WAIT_STATES_EN
  localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  // With zero wait cycles the access happens on the accept edge and uses
  // the live request; otherwise it uses the copy latched at accept time.
  always_comb begin
    if (state_q == S_WAIT) begin
      w_acc_we    = we_q;
      w_acc_addr  = addr_q;
      w_acc_wdata = wdata_q;
      w_acc_be    = be_q;
    end else begin
      w_acc_we    = bus.req_we;
      w_acc_addr  = bus.req_addr;
      w_acc_wdata = bus.req_wdata;
      w_acc_be    = bus.req_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
      if (w_accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_fire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (c_WAIT != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = c_WAIT;
          end else begin
            state_d = S_RESP;
            w_fire  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          w_fire  = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
`else
  assign w_acc_we    = bus.req_we;
  assign w_acc_addr  = bus.req_addr;
  assign w_acc_wdata = bus.req_wdata;
  assign w_acc_be    = bus.req_be;

  always_comb begin
    state_d = state_q;
    w_fire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_RESP;
          w_fire  = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
`endif

  // Unsigned offset from the base: addresses below the base wrap to a huge
  // offset and therefore fail the range test.
  assign w_off     = w_acc_addr - BASE_ADDR;
  assign w_acc_err = (w_acc_addr[1:0] != 2'b00) || ({1'b0, w_off} >= c_SPAN);
  assign w_idx     = w_off[c_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_fire) begin
        err_q   <= w_acc_err;
        rdata_q <= (!w_acc_err && !w_acc_we) ? mem_q[w_idx] : 32'd0;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_fire && w_acc_we && !w_acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A driver issues
//               directed requests and queues the expected response; a
//               monitor pops and compares each response as it is accepted
//               and checks the response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [31:0] c_BASE  = 32'h0000_1000;
  localparam int          c_DEPTH = 16;
`ifdef DMEM_WAIT_STATES_EN
  localparam int          c_W     = 3;
`else
  localparam int          c_W     = 0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;
  logic vprev;
  exp_t exp_q[$];

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (c_DEPTH),
    .BASE_ADDR   (c_BASE),
    .WAIT_CYCLES (3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor: samples 1 time unit after the falling edge, where the driver
  // has already settled its inputs for the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      vprev = 1'b0;
    end else begin
      if (bus.rsp_valid && !vprev) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
        end else begin
          chk("latency", 32'(cyc), 32'(exp_q[0].due));
        end
      end
      if (bus.rsp_valid && bus.rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
      vprev = bus.rsp_valid;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Returns at the falling edge right after the accept edge.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] erd, input logic eerr);
    exp_t e;
    int   k;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    k = 0;
    while (!bus.req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      fail_now("req_ready");
      bus.req_valid = 1'b0;
    end else begin
      // Accept edge is the next rising edge; response visible after edge N+W.
      e.rdata = erd;
      e.err   = eerr;
      e.due   = cyc + 1 + c_W;
      exp_q.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'hFFFF_FFFF;
      bus.req_wdata = 32'h0;
      bus.req_be    = 4'h0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      fail_now("response");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    n_vec = 0;
    n_bad = 0;
    vprev = 1'b0;
    rst   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    bus.rsp_ready = 1'b1;

    do_reset();

    // Seed word 0, then reset again: contents survive reset.
    xact(1'b1, c_BASE, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    wait_idle();
    do_reset();
    xact(1'b0, c_BASE, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    wait_idle();

    // Byte-enabled stores.
    xact(1'b1, c_BASE + 32'h10, 32'hAABB_CCDD, 4'b1111, 32'h0, 1'b0);
    xact(1'b1, c_BASE + 32'h10, 32'h0000_1122, 4'b0011, 32'h0, 1'b0);
    xact(1'b0, c_BASE + 32'h10, 32'h0,         4'b0000, 32'hAABB_1122, 1'b0);
    xact(1'b1, c_BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    xact(1'b0, c_BASE + 32'h10, 32'h0,         4'b0000, 32'hAABB_1122, 1'b0);
    xact(1'b1, c_BASE + 32'h14, 32'h0000_0000, 4'b1111, 32'h0, 1'b0);
    xact(1'b1, c_BASE + 32'h14, 32'h9900_0000, 4'b1000, 32'h0, 1'b0);
    xact(1'b0, c_BASE + 32'h14, 32'h0,         4'b0000, 32'h9900_0000, 1'b0);
    // Last valid word.
    xact(1'b1, c_BASE + 32'h3C, 32'h5A5A_5A5A, 4'b1111, 32'h0, 1'b0);
    xact(1'b0, c_BASE + 32'h3C, 32'h0,         4'b0000, 32'h5A5A_5A5A, 1'b0);
    wait_idle();

    // Error cases: misaligned, one past the end, below the base.
    xact(1'b0, c_BASE + 32'h13, 32'h0,         4'b0000, 32'h0, 1'b1);
    xact(1'b1, c_BASE + 32'h12, 32'h0,         4'b1111, 32'h0, 1'b1);
    xact(1'b1, c_BASE + 32'h40, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    xact(1'b0, c_BASE - 32'h4,  32'h0,         4'b0000, 32'h0, 1'b1);
    xact(1'b1, c_BASE - 32'h4,  32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    xact(1'b0, c_BASE,          32'h0,         4'b0000, 32'h1234_5678, 1'b0);
    xact(1'b0, c_BASE + 32'h10, 32'h0,         4'b0000, 32'hAABB_1122, 1'b0);
    xact(1'b0, c_BASE + 32'h3C, 32'h0,         4'b0000, 32'h5A5A_5A5A, 1'b0);
    wait_idle();

    // Response backpressure.
    bus.rsp_ready = 1'b0;
    xact(1'b0, c_BASE + 32'h10, 32'h0, 4'h0, 32'hAABB_1122, 1'b0);
    k = 0;
    while (!bus.rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) fail_now("bp_rsp_valid");
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'hAABB_1122);
      chk("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    wait_idle();

    // Reset in the middle of a store.
    xact(1'b1, c_BASE + 32'h20, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
    wait_idle();
    bus.rsp_ready = 1'b0;
    xact(1'b1, c_BASE + 32'h20, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    // With wait states the store was still in WAIT and must be lost;
    // without them it committed on the accept edge.
    xact(1'b0, c_BASE + 32'h20, 32'h0, 4'h0,
         (c_W > 0) ? 32'h0102_0304 : 32'hDEAD_BEEF, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
